// File: rtl/divisor_pkg.sv
// Shared types and two's-complement helpers for the sequential divider.
// Helpers work on a wide vector; callers widen to MAX_W and truncate back to their own width.
package divisor_pkg;

  typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} estado_t;

  localparam int MAX_W = 64;

  function automatic logic [MAX_W-1:0] nega_cond(input logic [MAX_W-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] v, input int unsigned msb,
                                               input logic sinalizado);
    return nega_cond(v, sinalizado & v[msb]);
  endfunction

endpackage

// File: rtl/divisor_passo.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor,
// and keep the difference only when it is non-negative.
module divisor_passo #(
  parameter int W = 16
) (
  input  logic [W:0]   i_resto,
  input  logic         i_bit,
  input  logic [W-1:0] i_divisor,
  output logic [W:0]   o_resto,
  output logic         o_bit_q
);

  logic [W+1:0] w_dif;

  // One guard bit above the shifted W+1-bit remainder carries the sign of the trial subtraction.
  assign w_dif   = {i_resto, i_bit} - {2'b00, i_divisor};
  assign o_bit_q = ~w_dif[W+1];
  assign o_resto = o_bit_q ? w_dif[W:0] : {i_resto[W-1:0], i_bit};

endmodule

// File: rtl/divisor_parametrizado.sv
// Parametrised sequential divider: one quotient bit per cycle, signed/unsigned per operation,
// divide-by-zero flag, start/ready/done_tick handshake.
module divisor_parametrizado
  import divisor_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sinalizado,
  input  logic [W-1:0] dividendo,
  input  logic [W-1:0] divisor,
  output logic         ready,
  output logic         done_tick,
  output logic [W-1:0] quociente,
  output logic [W-1:0] resto,
  output logic         div_zero
);

  localparam int CW = $clog2(W + 1);

  estado_t         r_estado;
  logic [CW-1:0]   r_cnt;
  logic [W:0]      r_rem;
  logic [W-1:0]    r_quo;
  logic [W-1:0]    r_div_mag;
  logic            r_sinal_q;
  logic            r_sinal_r;
  logic            r_zero;

  logic [W:0]      w_rem_next;
  logic            w_bit_q;
  logic [W-1:0]    w_dvd_mag;
  logic [W-1:0]    w_dvs_mag;

  function automatic logic [W-1:0] ajusta(input logic [W-1:0] v, input logic neg);
    logic [MAX_W-1:0] t;
    t = nega_cond(MAX_W'(v), neg);
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] magnitude(input logic [W-1:0] v, input logic sin);
    logic [MAX_W-1:0] t;
    t = abs_val(MAX_W'(v), W - 1, sin);
    return t[W-1:0];
  endfunction

  // The most-negative value maps to itself as a W-bit magnitude, which is what makes
  // most-negative / -1 come out as most-negative with a zero remainder.
  assign w_dvd_mag = magnitude(dividendo, sinalizado);
  assign w_dvs_mag = magnitude(divisor, sinalizado);

  divisor_passo #(.W(W)) u_passo (
    .i_resto   (r_rem),
    .i_bit     (r_quo[W-1]),
    .i_divisor (r_div_mag),
    .o_resto   (w_rem_next),
    .o_bit_q   (w_bit_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado  <= IDLE;
      ready     <= 1'b1;
      done_tick <= 1'b0;
      quociente <= '0;
      resto     <= '0;
      div_zero  <= 1'b0;
      r_cnt     <= '0;
      r_zero    <= 1'b0;
    end else begin
      case (r_estado)
        IDLE: begin
          done_tick <= 1'b0;
          if (start) begin
            ready     <= 1'b0;
            r_sinal_q <= sinalizado & (dividendo[W-1] ^ divisor[W-1]);
            r_sinal_r <= sinalizado & dividendo[W-1];
            r_div_mag <= w_dvs_mag;
            r_rem     <= '0;
            if (divisor == '0) begin
              // Raw dividend is parked in the quotient register and returned as the remainder.
              r_zero   <= 1'b1;
              r_quo    <= dividendo;
              r_estado <= FIX;
            end else begin
              r_zero   <= 1'b0;
              r_quo    <= w_dvd_mag;
              r_cnt    <= CW'(W);
              r_estado <= DIV;
            end
          end
        end
        DIV: begin
          r_rem <= w_rem_next;
          r_quo <= {r_quo[W-2:0], w_bit_q};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) r_estado <= FIX;
        end
        FIX: begin
          if (r_zero) begin
            quociente <= '1;
            resto     <= r_quo;
          end else begin
            quociente <= ajusta(r_quo, r_sinal_q);
            resto     <= ajusta(r_rem[W-1:0], r_sinal_r);
          end
          div_zero  <= r_zero;
          done_tick <= 1'b1;
          r_estado  <= DONE;
        end
        DONE: begin
          done_tick <= 1'b0;
          ready     <= 1'b1;
          r_estado  <= IDLE;
        end
        default: r_estado <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divisor_parametrizado.sv
// Directed bench for divisor_parametrizado at W=16 with hand-computed expected results.
module tb_divisor_parametrizado;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sinalizado = 1'b0;
  logic [W-1:0] dividendo = '0;
  logic [W-1:0] divisor = '0;
  logic         ready;
  logic         done_tick;
  logic [W-1:0] quociente;
  logic [W-1:0] resto;
  logic         div_zero;

  int checks = 0;
  int failures = 0;

  divisor_parametrizado #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .sinalizado (sinalizado),
    .dividendo  (dividendo),
    .divisor    (divisor),
    .ready      (ready),
    .done_tick  (done_tick),
    .quociente  (quociente),
    .resto      (resto),
    .div_zero   (div_zero)
  );

  always #5 clk = ~clk;

  // Issues one request at a negedge and returns the cycle index (start cycle = 0) of done_tick, 0 on timeout.
  task automatic run_op(input logic sig, input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    @(negedge clk);
    sinalizado = sig; dividendo = a; divisor = b; start = 1'b1;
    @(posedge clk);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (done_tick) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
    checks++; if (done_tick !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done_tick); end
    checks++; if (quociente !== 16'h0) begin failures++; $display("FAIL reset_quo got=%h exp=0000", quociente); end
    checks++; if (resto !== 16'h0) begin failures++; $display("FAIL reset_rem got=%h exp=0000", resto); end
    checks++; if (div_zero !== 1'b0) begin failures++; $display("FAIL reset_dz got=%b exp=0", div_zero); end
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    int lat;
    run_op(1'b0, 16'd40, 16'd2, lat);
    checks++; if (lat !== 18) begin failures++; $display("FAIL u40_2_latency got=%0d exp=18", lat); end
    checks++; if (quociente !== 16'd20) begin failures++; $display("FAIL u40_2_quo got=%h exp=0014", quociente); end
    checks++; if (resto !== 16'd0) begin failures++; $display("FAIL u40_2_rem got=%h exp=0000", resto); end
    checks++; if (div_zero !== 1'b0) begin failures++; $display("FAIL u40_2_dz got=%b exp=0", div_zero); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL u40_2_ready_in_done got=%b exp=0", ready); end
    @(negedge clk);
    checks++; if (done_tick !== 1'b0) begin failures++; $display("FAIL u40_2_done_width got=%b exp=0", done_tick); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL u40_2_ready_after got=%b exp=1", ready); end
    checks++; if (quociente !== 16'd20) begin failures++; $display("FAIL u40_2_hold got=%h exp=0014", quociente); end
  endtask

  task automatic test_signed();
    int lat;
    run_op(1'b1, 16'hFFF9, 16'h0002, lat);
    checks++; if (lat !== 18) begin failures++; $display("FAIL s_m7_2_latency got=%0d exp=18", lat); end
    checks++; if (quociente !== 16'hFFFD) begin failures++; $display("FAIL s_m7_2_quo got=%h exp=fffd", quociente); end
    checks++; if (resto !== 16'hFFFF) begin failures++; $display("FAIL s_m7_2_rem got=%h exp=ffff", resto); end
    run_op(1'b0, 16'hFFF9, 16'h0002, lat);
    checks++; if (quociente !== 16'h7FFC) begin failures++; $display("FAIL u_fff9_2_quo got=%h exp=7ffc", quociente); end
    checks++; if (resto !== 16'h0001) begin failures++; $display("FAIL u_fff9_2_rem got=%h exp=0001", resto); end
    run_op(1'b1, 16'h0007, 16'hFFFE, lat);
    checks++; if (quociente !== 16'hFFFD) begin failures++; $display("FAIL s_7_m2_quo got=%h exp=fffd", quociente); end
    checks++; if (resto !== 16'h0001) begin failures++; $display("FAIL s_7_m2_rem got=%h exp=0001", resto); end
  endtask

  task automatic test_div_zero();
    int lat;
    run_op(1'b0, 16'd100, 16'd0, lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL uz_latency got=%0d exp=2", lat); end
    checks++; if (quociente !== 16'hFFFF) begin failures++; $display("FAIL uz_quo got=%h exp=ffff", quociente); end
    checks++; if (resto !== 16'd100) begin failures++; $display("FAIL uz_rem got=%h exp=0064", resto); end
    checks++; if (div_zero !== 1'b1) begin failures++; $display("FAIL uz_dz got=%b exp=1", div_zero); end
    run_op(1'b1, 16'd100, 16'd0, lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL sz_latency got=%0d exp=2", lat); end
    checks++; if (quociente !== 16'hFFFF) begin failures++; $display("FAIL sz_quo got=%h exp=ffff", quociente); end
    checks++; if (resto !== 16'd100) begin failures++; $display("FAIL sz_rem got=%h exp=0064", resto); end
    checks++; if (div_zero !== 1'b1) begin failures++; $display("FAIL sz_dz got=%b exp=1", div_zero); end
    run_op(1'b0, 16'd350, 16'd17, lat);
    checks++; if (quociente !== 16'd20) begin failures++; $display("FAIL u350_17_quo got=%h exp=0014", quociente); end
    checks++; if (resto !== 16'd10) begin failures++; $display("FAIL u350_17_rem got=%h exp=000a", resto); end
    checks++; if (div_zero !== 1'b0) begin failures++; $display("FAIL u350_17_dz got=%b exp=0", div_zero); end
  endtask

  task automatic test_overflow();
    int lat;
    run_op(1'b1, 16'h8000, 16'hFFFF, lat);
    checks++; if (quociente !== 16'h8000) begin failures++; $display("FAIL s_ovf_quo got=%h exp=8000", quociente); end
    checks++; if (resto !== 16'h0000) begin failures++; $display("FAIL s_ovf_rem got=%h exp=0000", resto); end
    checks++; if (div_zero !== 1'b0) begin failures++; $display("FAIL s_ovf_dz got=%b exp=0", div_zero); end
    run_op(1'b0, 16'hFFFF, 16'h0001, lat);
    checks++; if (quociente !== 16'hFFFF) begin failures++; $display("FAIL u_ffff_1_quo got=%h exp=ffff", quociente); end
    checks++; if (resto !== 16'h0000) begin failures++; $display("FAIL u_ffff_1_rem got=%h exp=0000", resto); end
  endtask

  task automatic test_ignore_inputs();
    int lat;
    @(negedge clk);
    sinalizado = 1'b0; dividendo = 16'd40; divisor = 16'd2; start = 1'b1;
    @(posedge clk);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 3) begin sinalizado = 1'b1; dividendo = 16'd999; divisor = 16'd5; start = 1'b1; end
      if (c == 4) start = 1'b0;
      if (done_tick) begin lat = c; break; end
    end
    checks++; if (lat !== 18) begin failures++; $display("FAIL ign_latency got=%0d exp=18", lat); end
    checks++; if (quociente !== 16'd20) begin failures++; $display("FAIL ign_quo got=%h exp=0014", quociente); end
    checks++; if (resto !== 16'd0) begin failures++; $display("FAIL ign_rem got=%h exp=0000", resto); end
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    @(negedge clk);
    sinalizado = 1'b0; dividendo = 16'd1000; divisor = 16'd3; start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL rmid_ready got=%b exp=1", ready); end
    checks++; if (quociente !== 16'd0) begin failures++; $display("FAIL rmid_quo got=%h exp=0000", quociente); end
    checks++; if (resto !== 16'd0) begin failures++; $display("FAIL rmid_rem got=%h exp=0000", resto); end
    seen = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (done_tick) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL rmid_no_done got=%0d exp=0", seen); end
    run_op(1'b0, 16'd240, 16'd12, lat);
    checks++; if (lat !== 18) begin failures++; $display("FAIL r240_12_latency got=%0d exp=18", lat); end
    checks++; if (quociente !== 16'd20) begin failures++; $display("FAIL r240_12_quo got=%h exp=0014", quociente); end
    checks++; if (resto !== 16'd0) begin failures++; $display("FAIL r240_12_rem got=%h exp=0000", resto); end
  endtask

  task automatic test_back_to_back();
    int first;
    int second;
    @(negedge clk);
    sinalizado = 1'b0; dividendo = 16'd350; divisor = 16'd17; start = 1'b1;
    @(posedge clk);
    first = 0; second = 0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (done_tick && first == 0) begin
        first = c;
        checks++; if (quociente !== 16'd20) begin failures++; $display("FAIL b2b_1_quo got=%h exp=0014", quociente); end
        checks++; if (resto !== 16'd10) begin failures++; $display("FAIL b2b_1_rem got=%h exp=000a", resto); end
        dividendo = 16'd1000; divisor = 16'd7;
      end else if (done_tick) begin
        second = c;
        break;
      end
    end
    start = 1'b0;
    checks++; if (first !== 18) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=18", first); end
    checks++; if (second !== 37) begin failures++; $display("FAIL b2b_second_cycle got=%0d exp=37", second); end
    checks++; if (quociente !== 16'd142) begin failures++; $display("FAIL b2b_2_quo got=%h exp=008e", quociente); end
    checks++; if (resto !== 16'd6) begin failures++; $display("FAIL b2b_2_rem got=%h exp=0006", resto); end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_ignore_inputs();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
